// File: rtl/rv32i_memstage_hs_if.sv
// Data-memory port: request/ack handshake with byte-lane write data and a read word.
interface rv32i_memstage_hs_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/rv32i_memstage_hs.sv
// RV32I memory stage: request issued combinationally, result in W one edge after ack (or fault);
// StallM holds the pipeline until ack, and a timeout aborts the access.
module rv32i_memstage_hs #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ValidM,
  input  logic                RegWriteM,
  input  logic [1:0]          ResultSrcM,
  input  logic                MemReadM,
  input  logic                MemWriteM,
  input  logic [2:0]          SizeM,
  input  logic [31:0]         ALUResultM,
  input  logic [31:0]         WriteDataM,
  input  logic [31:0]         PCPlus4M,
  input  logic [4:0]          RdM,
  rv32i_memstage_hs_if.master dmem,
  output logic                StallM,
  output logic                RegWriteW,
  output logic [4:0]          RdW,
  output logic [1:0]          ResultSrcW,
  output logic [31:0]         ALUResultW,
  output logic [31:0]         ReadDataW,
  output logic [31:0]         PCPlus4W,
  output logic                ValidW,
  output logic                MisalignW,
  output logic                TimeoutW
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lane;
  logic             misalign, access, mis_fault, mem_op;
  logic             timeout_hit, abort, ack_ok, fault;
  logic [ADDR_W+1:0] addr_wide;
  logic [31:0]      shifted, load_data;
  logic [15:0]      half;

  assign lane = ALUResultM[1:0];

  always_comb begin
    misalign = 1'b0;
    case (SizeM[1:0])
      2'b01:   misalign = lane[0];
      2'b10:   misalign = |lane;
      default: misalign = 1'b0;
    endcase
  end

  assign access    = ValidM & (MemReadM | MemWriteM);
  assign mis_fault = access & misalign;
  assign mem_op    = access & ~misalign;

  // cnt only reaches TIMEOUT while waiting; a same-cycle ack beats the abort
  assign timeout_hit = (TIMEOUT != 0) && (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT));
  assign abort       = mem_op & timeout_hit & ~dmem.ack;

  assign dmem.req = rst & mem_op & ~abort;
  assign dmem.we  = rst & MemWriteM;
  assign ack_ok   = dmem.req & dmem.ack;
  assign StallM   = dmem.req & ~dmem.ack;
  assign fault    = mis_fault | abort;

  assign addr_wide = (ADDR_W + 2)'(ALUResultM);
  assign dmem.addr = addr_wide[ADDR_W+1:2];

  always_comb begin
    dmem.be    = 4'b1111;
    dmem.wdata = WriteDataM;
    case (SizeM[1:0])
      2'b00: begin
        dmem.be    = 4'b0001 << lane;
        dmem.wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        dmem.be    = 4'b0011 << lane;
        dmem.wdata = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = dmem.rdata >> {lane, 3'b000};
  assign half    = lane[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

  always_comb begin
    load_data = dmem.rdata;
    case (SizeM)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'b0, shifted[7:0]};
      3'b001:  load_data = {{16{half[15]}}, half};
      3'b101:  load_data = {16'b0, half};
      default: load_data = dmem.rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (StallM) begin
      state <= S_WAIT;
      cnt   <= cnt + CNT_W'(1);
    end else begin
      state <= S_IDLE;
      cnt   <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      MisalignW  <= 1'b0;
      TimeoutW   <= 1'b0;
      RdW        <= '0;
      ResultSrcW <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
    end else if (StallM) begin
      ValidW    <= 1'b0;
      RegWriteW <= 1'b0;
      MisalignW <= 1'b0;
      TimeoutW  <= 1'b0;
    end else begin
      ValidW     <= ValidM;
      RegWriteW  <= RegWriteM & ValidM & ~fault;
      MisalignW  <= mis_fault;
      TimeoutW   <= abort;
      RdW        <= RdM;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      if (ack_ok) ReadDataW <= load_data;
    end
  end
endmodule

// File: doc/rv32i_memstage_hs.md
Name: rv32i_memstage_hs

Overview:
- Next-generation RV32I memory stage: drives a handshaked data-memory port with variable wait states, generates store byte enables and write-data lanes, and size/sign-converts load data.
- Stalls the pipeline while an access is outstanding, flags misaligned and timed-out accesses, and registers results into the DM/WB pipeline register.
- Sits between the EX/MEM register and the writeback stage; StallM feeds the hazard unit.

Parameters:
- ADDR_W, 32, width of dmem_addr_o (word address = ALUResultM[ADDR_W+1:2]).
- TIMEOUT, 16, maximum wait cycles before abort; 0 disables timeout.
- CNT_W, 5, wait-counter width; must be at least clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ValidM  in  1  instruction in M is valid.
- RegWriteM  in  1  register write enable.
- ResultSrcM  in  2  writeback select, passed through.
- MemReadM  in  1  load.
- MemWriteM  in  1  store.
- SizeM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use bits [1:0].
- ALUResultM  in  32  effective address / ALU result.
- WriteDataM  in  32  store data in the low bits.
- PCPlus4M  in  32  PC+4.
- RdM  in  5  destination register.
- dmem_req_o  out  1  access request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  ADDR_W  word address.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_ack_i  in  1  access complete; rdata valid in the same cycle.
- dmem_rdata_i  in  32  read word.
- StallM  out  1  freeze IF through M.
- RegWriteW  out  1  writeback enable.
- RdW  out  5  destination register.
- ResultSrcW  out  2  writeback select.
- ALUResultW  out  32  ALU result.
- ReadDataW  out  32  converted load data.
- PCPlus4W  out  32  PC+4.
- ValidW  out  1  W holds a retired instruction.
- MisalignW  out  1  retired instruction faulted: misaligned address.
- TimeoutW  out  1  retired instruction faulted: access timeout.

Behaviour:
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
- MemOp = ValidM & (MemReadM | MemWriteM) & ~misaligned.
- FSM states: IDLE, WAIT. Wait counter cnt resets to 0.
- dmem_req_o = MemOp & ~abort, combinational; it is asserted in the first cycle, with no registered latency. dmem_we_o = MemWriteM. Forced to 0 while rst is low.
- Zero-wait access (ack in the request cycle):
  - StallM = 0.
  - W loads the instruction at the next edge.
  - State stays IDLE.
- IDLE to WAIT: MemOp & ~ack. StallM = 1 and cnt increments.
- WAIT, ack received: StallM = 0, W loads, go to IDLE, cnt := 0.
- Timeout abort: when TIMEOUT≠0 and cnt == TIMEOUT and ~ack:
  - abort = 1, so dmem_req_o = 0 and StallM = 0.
  - W loads with TimeoutW = 1 and RegWriteW = 0.
  - Go to IDLE.
- ack on the timeout cycle: ack wins, no fault.
- While StallM = 1, W loads a bubble: ValidW = 0, RegWriteW = 0, other W fields hold.
- When not stalled, W loads from the M inputs every cycle; RegWriteW = RegWriteM & ValidM & ~fault.
- Misaligned op:
  - No request and no stall.
  - W loads with MisalignW = 1, RegWriteW = 0.
  - Fault flags last one cycle per retired instruction.
- Store byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << addr[1:0].
  - W: 1111.
- Store write data:
  - B: byte replicated ×4.
  - H: half replicated ×2.
  - W: as is.
- Load conversion (from dmem_rdata_i, captured on ack):
  - Lane is selected by addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W pass-through.
- ack while dmem_req_o = 0: ignored.
- Reset (async, any state):
  - State IDLE, cnt 0.
  - All W outputs 0 (ValidW, RegWriteW, flags, data, Rd).
  - StallM = 0.
  - An outstanding access is abandoned and a later stray ack is ignored.
- Non-memory valid instruction: passes to W in 1 cycle, no stall.

Test Plan:
- LW at 0x100, ack in the same cycle, rdata 0xDEADBEEF → no stall; next cycle ReadDataW = 0xDEADBEEF, RegWriteW = 1, ValidW = 1.
- LB at 0x103, rdata 0x80AABBCC, ack after 3 wait cycles → StallM high for 3 cycles with W bubbles (RegWriteW = 0); then ReadDataW = 0xFFFFFF80. LBU, same case → 0x00000080.
- SH at 0x102, WriteDataM 0x1234ABCD → dmem_be_o = 1100, dmem_wdata_o = 0xABCDABCD, dmem_we_o = 1. SB at 0x001 → be = 0010.
- LW at 0x102 → no request, no stall; W: MisalignW = 1, RegWriteW = 0, ValidW = 1.
- TIMEOUT = 4, no ack → StallM high for 4 cycles; abort cycle has req = 0; W: TimeoutW = 1, RegWriteW = 0. Repeat with ack on the 4th wait cycle → normal completion, no fault.
- Assert rst low during WAIT → all outputs 0 immediately. Release, then pulse stray ack → no W update, state IDLE.
